// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: state encoding,
// instruction word field positions and the field extraction helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_IMM = 3'd1,
    ISSUE     = 3'd2,
    DRAIN     = 3'd3,
    HALTED    = 3'd4
  } fetch_state_e;

  localparam logic [4:0] NOP_OP = 5'h00;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 27;
  localparam int S1_MSB   = 26;
  localparam int S1_LSB   = 23;
  localparam int S2_MSB   = 22;
  localparam int S2_LSB   = 19;
  localparam int DEST_MSB = 18;
  localparam int DEST_LSB = 15;

  // Opcode bit that marks a two-word instruction (opcode word + immediate word).
  localparam int IMM_FLAG_BIT = 4;

  typedef struct packed {
    logic [4:0] opcode;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] dest;
  } instr_t;

  localparam instr_t NOP_INSTR = '{opcode: NOP_OP, s1: 4'h0, s2: 4'h0, dest: 4'h0};

  // Only the upper field bits are meaningful; the low 15 bits of a word are ignored.
  function automatic instr_t decode_word(input logic [31:15] w);
    instr_t f;
    f.opcode = w[OP_MSB:OP_LSB];
    f.s1     = w[S1_MSB:S1_LSB];
    f.s2     = w[S2_MSB:S2_LSB];
    f.dest   = w[DEST_MSB:DEST_LSB];
    return f;
  endfunction

  function automatic logic has_imm(input logic [4:0] op);
    return op[IMM_FLAG_BIT];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack port; the fetch unit is the master.
interface fetch_unit_if #(
  parameter int unsigned PC_W = 8
) ();

  logic            imem_req_f;
  logic [PC_W-1:0] imem_addr_f;
  logic            imem_ack_f;
  logic [31:0]     imem_rdata_f;

  modport master (
    output imem_req_f,
    output imem_addr_f,
    input  imem_ack_f,
    input  imem_rdata_f
  );

  modport slave (
    input  imem_req_f,
    input  imem_addr_f,
    output imem_ack_f,
    output imem_rdata_f
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches opcode (+ optional immediate)
// words over a req/ack port and presents one registered instruction per issue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter logic [4:0]      HALT_OP  = 5'h0F
) (
  input  logic              clk_f,
  input  logic              reset_n_f,
  fetch_unit_if.master      imem,
  input  logic              stall_f,
  input  logic              branch_taken_f,
  input  logic [PC_W-1:0]   branch_target_f,
  output logic [4:0]        opcode_out_f,
  output logic [3:0]        s1_out_f,
  output logic [3:0]        s2_out_f,
  output logic [3:0]        dest_out_f,
  output logic [31:0]       ime_data_out_f,
  output logic              halted_f
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] addr_q, addr_d;
  instr_t          buf_q, buf_d;
  logic [31:0]     buf_imm_q, buf_imm_d;
  instr_t          out_q, out_d;
  logic [31:0]     imm_out_q, imm_out_d;
  logic            halted_q, halted_d;

  logic            ack_v_s;
  instr_t          word_s;
  logic            unused_rdata_s;

  assign ack_v_s        = imem.imem_ack_f & req_q;
  assign word_s         = decode_word(imem.imem_rdata_f[31:15]);
  assign unused_rdata_s = ^imem.imem_rdata_f[14:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    buf_imm_d = buf_imm_q;
    out_d     = NOP_INSTR;
    imm_out_d = 32'h0000_0000;

    // A branch overrides everything; an unacked request must still be drained.
    if (branch_taken_f) begin
      pc_d      = branch_target_f;
      buf_d     = NOP_INSTR;
      buf_imm_d = 32'h0000_0000;
      if (req_q && !imem.imem_ack_f) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH_OP;
      end
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (ack_v_s) begin
            buf_d = word_s;
            pc_d  = pc_q + PC_ONE;
            if (has_imm(word_s.opcode)) begin
              state_d = FETCH_IMM;
            end else begin
              buf_imm_d = 32'h0000_0000;
              state_d   = ISSUE;
            end
          end else begin
            state_d = FETCH_OP;
          end
        end
        FETCH_IMM: begin
          if (ack_v_s) begin
            buf_imm_d = imem.imem_rdata_f;
            pc_d      = pc_q + PC_ONE;
            state_d   = ISSUE;
          end else begin
            state_d = FETCH_IMM;
          end
        end
        ISSUE: begin
          if (stall_f) begin
            state_d = ISSUE;
          end else begin
            out_d     = buf_q;
            imm_out_d = buf_imm_q;
            if (buf_q.opcode == HALT_OP) begin
              state_d = HALTED;
            end else begin
              state_d = FETCH_OP;
            end
          end
        end
        DRAIN: begin
          if (ack_v_s) begin
            state_d = FETCH_OP;
          end else begin
            state_d = DRAIN;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = FETCH_OP;
        end
      endcase
    end

    // Request lines are registered, so they are derived from the next state.
    req_d    = (state_d == FETCH_OP) || (state_d == FETCH_IMM) || (state_d == DRAIN);
    addr_d   = (state_d == DRAIN) ? addr_q : pc_d;
    halted_d = (state_d == HALTED);
  end

  // State, PC, pending buffer and all registered outputs.
  always_ff @(posedge clk_f or negedge reset_n_f) begin
    if (!reset_n_f) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      buf_q     <= NOP_INSTR;
      buf_imm_q <= 32'h0000_0000;
      out_q     <= NOP_INSTR;
      imm_out_q <= 32'h0000_0000;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      buf_imm_q <= buf_imm_d;
      out_q     <= out_d;
      imm_out_q <= imm_out_d;
      halted_q  <= halted_d;
    end
  end

  assign imem.imem_req_f  = req_q;
  assign imem.imem_addr_f = addr_q;
  assign opcode_out_f     = out_q.opcode;
  assign s1_out_f         = out_q.s1;
  assign s2_out_f         = out_q.s2;
  assign dest_out_f       = out_q.dest;
  assign ime_data_out_f   = imm_out_q;
  assign halted_f         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-stepped memory responder with
// programmable ack delay drives the imem port; outputs are sampled on negedges.
module tb_fetch_unit;

  logic        clk_f = 1'b0;
  logic        reset_n_f;
  logic        stall_f;
  logic        branch_taken_f;
  logic [7:0]  branch_target_f;
  logic [4:0]  opcode_out_f;
  logic [3:0]  s1_out_f;
  logic [3:0]  s2_out_f;
  logic [3:0]  dest_out_f;
  logic [31:0] ime_data_out_f;
  logic        halted_f;

  logic [31:0] mem [0:255];
  int          mem_delay;
  int          cnt;
  int          checks = 0;
  int          errors = 0;

  fetch_unit_if #(.PC_W(8)) imem_if ();

  fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .HALT_OP(5'h0F)) dut (
    .clk_f           (clk_f),
    .reset_n_f       (reset_n_f),
    .imem            (imem_if),
    .stall_f         (stall_f),
    .branch_taken_f  (branch_taken_f),
    .branch_target_f (branch_target_f),
    .opcode_out_f    (opcode_out_f),
    .s1_out_f        (s1_out_f),
    .s2_out_f        (s2_out_f),
    .dest_out_f      (dest_out_f),
    .ime_data_out_f  (ime_data_out_f),
    .halted_f        (halted_f)
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, then decide ack/rdata for the coming posedge.
  task automatic step();
    @(negedge clk_f);
    if (imem_if.imem_ack_f) begin
      imem_if.imem_ack_f = 1'b0;
      cnt = imem_if.imem_req_f ? 1 : 0;
    end else if (imem_if.imem_req_f) begin
      cnt++;
      if (cnt > mem_delay) begin
        imem_if.imem_ack_f   = 1'b1;
        imem_if.imem_rdata_f = mem[imem_if.imem_addr_f];
      end
    end else begin
      cnt = 0;
    end
  endtask

  // Reset, then release with a branch so fetching starts cleanly at tgt.
  task automatic start(input logic [7:0] tgt, input int dly);
    reset_n_f          = 1'b0;
    imem_if.imem_ack_f = 1'b0;
    stall_f            = 1'b0;
    cnt                = 0;
    mem_delay          = dly;
    @(negedge clk_f);
    reset_n_f       = 1'b1;
    branch_taken_f  = 1'b1;
    branch_target_f = tgt;
    step();
    branch_taken_f = 1'b0;
  endtask

  task automatic chk_fields(input string tag, input logic [4:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] d, input logic [31:0] imm);
    chk({tag, "_op"}, 32'(opcode_out_f), 32'(op));
    chk({tag, "_s1"}, 32'(s1_out_f), 32'(a));
    chk({tag, "_s2"}, 32'(s2_out_f), 32'(b));
    chk({tag, "_dest"}, 32'(dest_out_f), 32'(d));
    chk({tag, "_imm"}, ime_data_out_f, imm);
  endtask

  int n_hit;
  int n_other;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[8'h00] = 32'h1891_8000;  // op 03 s1 1 s2 2 dest 3
    mem[8'h02] = 32'h7800_0000;  // HALT (op 0F)
    mem[8'h04] = 32'h9000_0000;  // op 12, immediate follows
    mem[8'h05] = 32'hDEAD_BEEF;
    mem[8'h06] = 32'h1888_8000;  // op 03 s1 1 s2 1 dest 1
    mem[8'h07] = 32'h1D00_0000;  // op 03 s1 A
    mem[8'h08] = 32'h1AB3_8000;  // op 03 s1 5 s2 6 dest 7
    mem[8'h20] = 32'h1D80_0000;  // op 03 s1 B
    mem[8'hFF] = 32'h9A2B_0000;  // op 13 s1 4 s2 5 dest 6, immediate at 0x00

    reset_n_f            = 1'b0;
    stall_f              = 1'b0;
    branch_taken_f       = 1'b0;
    branch_target_f      = 8'h00;
    imem_if.imem_ack_f   = 1'b0;
    imem_if.imem_rdata_f = 32'h0000_0000;
    mem_delay            = 1;
    cnt                  = 0;

    step(); step(); step();
    chk("rst_req", 32'(imem_if.imem_req_f), 32'd0);
    chk("rst_addr", 32'(imem_if.imem_addr_f), 32'd0);
    chk_fields("rst", 5'h00, 4'h0, 4'h0, 4'h0, 32'h0);
    chk("rst_halted", 32'(halted_f), 32'd0);

    // Plain fetch; a stray ack while req is still low must be ignored.
    reset_n_f            = 1'b1;
    imem_if.imem_ack_f   = 1'b1;
    imem_if.imem_rdata_f = 32'hFFFF_FFFF;
    step();
    chk("t1_req_rise", 32'(imem_if.imem_req_f), 32'd1);
    chk("t1_addr0", 32'(imem_if.imem_addr_f), 32'd0);
    chk("t1_nop_a", 32'(opcode_out_f), 32'd0);
    step();
    chk("t1_nop_b", 32'(opcode_out_f), 32'd0);
    chk("t1_req_held", 32'(imem_if.imem_req_f), 32'd1);
    step();
    chk("t1_req_drop", 32'(imem_if.imem_req_f), 32'd0);
    chk("t1_nop_c", 32'(opcode_out_f), 32'd0);
    step();
    chk_fields("t1_issue", 5'h03, 4'h1, 4'h2, 4'h3, 32'h0);
    chk("t1_next_req", 32'(imem_if.imem_req_f), 32'd1);
    chk("t1_next_addr", 32'(imem_if.imem_addr_f), 32'd1);
    step();
    chk("t1_nop_after", 32'(opcode_out_f), 32'd0);

    // Asynchronous reset drops req without waiting for a clock edge.
    reset_n_f = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_if.imem_req_f), 32'd0);

    // Immediate instruction with 3-cycle ack delay.
    start(8'h04, 3);
    n_hit = 0;
    n_other = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (opcode_out_f == 5'h12) begin
        n_hit++;
        chk("t2_imm", ime_data_out_f, 32'hDEAD_BEEF);
        chk("t2_next_addr", 32'(imem_if.imem_addr_f), 32'd6);
        chk("t2_next_req", 32'(imem_if.imem_req_f), 32'd1);
      end
      if (opcode_out_f == 5'h03 && s1_out_f == 4'h1) begin
        n_other++;
        chk("t2_noimm_zero", ime_data_out_f, 32'h0);
      end
    end
    chk("t2_issue_once", 32'(n_hit), 32'd1);
    chk("t2_follow_once", 32'(n_other), 32'd1);

    // Stall for 4 cycles in ISSUE.
    start(8'h08, 1);
    stall_f = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_stall_nop", 32'(opcode_out_f), 32'd0);
      chk("t3_stall_noreq", 32'(imem_if.imem_req_f), 32'd0);
    end
    stall_f = 1'b0;
    step();
    chk_fields("t3_issue", 5'h03, 4'h5, 4'h6, 4'h7, 32'h0);
    chk("t3_next_addr", 32'(imem_if.imem_addr_f), 32'd9);
    step();
    chk("t3_nop_after", 32'(opcode_out_f), 32'd0);

    // Branch while a request to 7 is outstanding: drain, then fetch 0x40.
    start(8'h07, 2);
    branch_taken_f  = 1'b1;
    branch_target_f = 8'h40;
    step();
    branch_taken_f = 1'b0;
    chk("t4_drain_req", 32'(imem_if.imem_req_f), 32'd1);
    chk("t4_drain_addr_a", 32'(imem_if.imem_addr_f), 32'd7);
    chk("t4_nop", 32'(opcode_out_f), 32'd0);
    step();
    chk("t4_drain_addr_b", 32'(imem_if.imem_addr_f), 32'd7);
    step();
    chk("t4_target_req", 32'(imem_if.imem_req_f), 32'd1);
    chk("t4_target_addr", 32'(imem_if.imem_addr_f), 32'h40);
    n_hit = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (opcode_out_f == 5'h03 && s1_out_f == 4'hA) n_hit++;
    end
    chk("t4_dropped", 32'(n_hit), 32'd0);

    // Branch coinciding with an ack: data dropped, no drain.
    start(8'h20, 1);
    step();
    branch_taken_f  = 1'b1;
    branch_target_f = 8'h50;
    step();
    branch_taken_f = 1'b0;
    chk("t4b_req", 32'(imem_if.imem_req_f), 32'd1);
    chk("t4b_addr", 32'(imem_if.imem_addr_f), 32'h50);
    n_hit = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (opcode_out_f == 5'h03 && s1_out_f == 4'hB) n_hit++;
    end
    chk("t4b_dropped", 32'(n_hit), 32'd0);

    // Immediate instruction at 0xFF; immediate word wraps to address 0.
    start(8'hFF, 1);
    chk("t5_addr_ff", 32'(imem_if.imem_addr_f), 32'hFF);
    step();
    step();
    chk("t5_imm_req", 32'(imem_if.imem_req_f), 32'd1);
    chk("t5_imm_addr", 32'(imem_if.imem_addr_f), 32'd0);
    step();
    step();
    chk("t5_req_drop", 32'(imem_if.imem_req_f), 32'd0);
    chk("t5_nop", 32'(opcode_out_f), 32'd0);
    step();
    chk_fields("t5_issue", 5'h13, 4'h4, 4'h5, 4'h6, 32'h1891_8000);
    chk("t5_next_addr", 32'(imem_if.imem_addr_f), 32'd1);
    step();
    chk("t5_nop_after", 32'(opcode_out_f), 32'd0);

    // HALT: issued once, then idle until a branch.
    start(8'h02, 1);
    step();
    step();
    chk("t6_not_yet_halted", 32'(halted_f), 32'd0);
    step();
    chk("t6_halt_op", 32'(opcode_out_f), 32'h0F);
    chk("t6_halted", 32'(halted_f), 32'd1);
    chk("t6_req", 32'(imem_if.imem_req_f), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 5) begin
        imem_if.imem_ack_f   = 1'b1;
        imem_if.imem_rdata_f = 32'h1891_8000;
      end
      chk("t6_idle_req", 32'(imem_if.imem_req_f), 32'd0);
      chk("t6_idle_halted", 32'(halted_f), 32'd1);
      chk("t6_idle_nop", 32'(opcode_out_f), 32'd0);
    end
    branch_taken_f  = 1'b1;
    branch_target_f = 8'h10;
    step();
    branch_taken_f = 1'b0;
    chk("t6_unhalt", 32'(halted_f), 32'd0);
    chk("t6_br_req", 32'(imem_if.imem_req_f), 32'd1);
    chk("t6_br_addr", 32'(imem_if.imem_addr_f), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
